// File: rtl/lm32_dp_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external registered-read dual-port RAM.
// A 2-entry output queue absorbs the one-cycle read latency so both sides run at one word per cycle.
module lm32_dp_fifo_ctrl #(
  parameter int data_width = 32,
  parameter int addr_width = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [data_width-1:0] push_data_i,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  output logic [data_width-1:0] pop_data_o,
  output logic                  pop_valid_o,
  input  logic                  pop_ready_i,
  output logic                  ram_we_o,
  output logic [addr_width-1:0] ram_waddr_o,
  output logic [data_width-1:0] ram_wdata_o,
  output logic [addr_width-1:0] ram_raddr_o,
  input  logic [data_width-1:0] ram_rdata_i,
  output logic [addr_width+1:0] level_o
);

  localparam logic [addr_width:0] full_count = {1'b1, {addr_width{1'b0}}};

  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_ptr;
  logic [addr_width:0]   ram_count;
  logic                  inflight;
  logic [1:0]            oq_count;
  logic [data_width-1:0] oq0;
  logic [data_width-1:0] oq1;

  logic                  push_fire;
  logic                  pop_fire;
  logic                  issue;
  logic [1:0]            oq_after_pop;
  logic [1:0]            occ_after_pop;

  always_comb begin
    push_ready_o  = (ram_count != full_count);
    push_fire     = push_valid_i & push_ready_o;
    pop_valid_o   = (oq_count != 2'd0);
    pop_fire      = pop_valid_o & pop_ready_i;
    oq_after_pop  = oq_count - {1'b0, pop_fire};
    // Words already committed to the queue once this edge's pop is taken into account.
    occ_after_pop = oq_after_pop + {1'b0, inflight};
    issue         = (ram_count != '0) && (occ_after_pop < 2'd2);
  end

  assign ram_we_o    = push_fire;
  assign ram_waddr_o = wr_ptr;
  assign ram_wdata_o = push_data_i;
  assign ram_raddr_o = rd_ptr;
  assign pop_data_o  = oq0;
  assign level_o     = {1'b0, ram_count}
                     + {{(addr_width+1){1'b0}}, inflight}
                     + {{addr_width{1'b0}}, oq_count};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      inflight  <= 1'b0;
      oq_count  <= 2'd0;
      oq0       <= '0;
      oq1       <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (issue)     rd_ptr <= rd_ptr + 1'b1;
      inflight <= issue;

      case ({push_fire, issue})
        2'b10:   ram_count <= ram_count + 1'b1;
        2'b01:   ram_count <= ram_count - 1'b1;
        default: ram_count <= ram_count;
      endcase

      if (pop_fire) oq0 <= oq1;
      // Landing word goes to the first free slot after the pop; overrides the shift into oq0.
      if (inflight) begin
        if (oq_after_pop == 2'd0) oq0 <= ram_rdata_i;
        else                      oq1 <= ram_rdata_i;
      end
      oq_count <= oq_after_pop + {1'b0, inflight};
    end
  end

endmodule

// File: tb/tb_lm32_dp_fifo_ctrl.sv
// Directed bench for lm32_dp_fifo_ctrl: two instances (addr_width 2 and 3), each with a behavioural
// registered-read RAM, checked against a scoreboard of accepted words and hand-derived timing.
module tb_lm32_dp_fifo_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance A: addr_width = 2
  logic [31:0] a_push_data, a_pop_data, a_ram_wdata, a_ram_rdata;
  logic        a_push_valid, a_push_ready, a_pop_valid, a_pop_ready, a_ram_we;
  logic [1:0]  a_ram_waddr, a_ram_raddr, a_raddr_q;
  logic [3:0]  a_level;
  logic [31:0] a_mem [4];

  // instance B: addr_width = 3
  logic [31:0] b_push_data, b_pop_data, b_ram_wdata, b_ram_rdata;
  logic        b_push_valid, b_push_ready, b_pop_valid, b_pop_ready, b_ram_we;
  logic [2:0]  b_ram_waddr, b_ram_raddr, b_raddr_q;
  logic [4:0]  b_level;
  logic [31:0] b_mem [8];

  lm32_dp_fifo_ctrl #(.data_width(32), .addr_width(2)) u_a (
    .clk_i(clk), .rst_i(rst),
    .push_data_i(a_push_data), .push_valid_i(a_push_valid), .push_ready_o(a_push_ready),
    .pop_data_o(a_pop_data), .pop_valid_o(a_pop_valid), .pop_ready_i(a_pop_ready),
    .ram_we_o(a_ram_we), .ram_waddr_o(a_ram_waddr), .ram_wdata_o(a_ram_wdata),
    .ram_raddr_o(a_ram_raddr), .ram_rdata_i(a_ram_rdata), .level_o(a_level)
  );

  lm32_dp_fifo_ctrl #(.data_width(32), .addr_width(3)) u_b (
    .clk_i(clk), .rst_i(rst),
    .push_data_i(b_push_data), .push_valid_i(b_push_valid), .push_ready_o(b_push_ready),
    .pop_data_o(b_pop_data), .pop_valid_o(b_pop_valid), .pop_ready_i(b_pop_ready),
    .ram_we_o(b_ram_we), .ram_waddr_o(b_ram_waddr), .ram_wdata_o(b_ram_wdata),
    .ram_raddr_o(b_ram_raddr), .ram_rdata_i(b_ram_rdata), .level_o(b_level)
  );

  always @(posedge clk) begin
    if (a_ram_we) a_mem[a_ram_waddr] <= a_ram_wdata;
    a_raddr_q <= a_ram_raddr;
    if (b_ram_we) b_mem[b_ram_waddr] <= b_ram_wdata;
    b_raddr_q <= b_ram_raddr;
  end
  assign a_ram_rdata = a_mem[a_raddr_q];
  assign b_ram_rdata = b_mem[b_raddr_q];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sbq_a [$];
  logic [31:0] sbq_b [$];
  bit pu, po;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; drives one cycle, scores fires, returns #1 after the next edge.
  task automatic a_cycle(input logic pv, input logic [31:0] pd, input logic pr,
                         output bit pushed, output bit popped);
    logic [31:0] exp;
    a_push_valid = pv; a_push_data = pd; a_pop_ready = pr;
    #1;
    pushed = pv && a_push_ready;
    popped = a_pop_valid && pr;
    chk("a_ram_we", a_ram_we, pushed);
    if (pushed) begin
      chk("a_ram_wdata", a_ram_wdata, pd);
      sbq_a.push_back(pd);
    end
    if (popped) begin
      exp = (sbq_a.size() > 0) ? sbq_a[0] : 32'hDEAD_BEEF;
      chk("a_pop_data", a_pop_data, exp);
      if (sbq_a.size() > 0) void'(sbq_a.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic a_drain(input string tag);
    int budget;
    bit p1, p2;
    budget = 0;
    while (sbq_a.size() > 0 && budget < 50) begin
      a_cycle(1'b0, 32'h0, 1'b1, p1, p2);
      budget++;
    end
    chk(tag, sbq_a.size(), 0);
  endtask

  int accepted, pops, first_pop, level_bad;
  int b_pushed_n, b_popped_n, cyc;
  logic        b_prev_stall;
  logic [31:0] b_prev_data, b_exp;

  initial begin
    rst = 1'b1;
    a_push_valid = 0; a_push_data = 0; a_pop_ready = 0;
    b_push_valid = 0; b_push_data = 0; b_pop_ready = 0;
    #23 rst = 1'b0;
    @(posedge clk); #1;

    // reset state
    chk("rst_push_ready", a_push_ready, 1);
    chk("rst_pop_valid", a_pop_valid, 0);
    chk("rst_pop_data", a_pop_data, 0);
    chk("rst_ram_we", a_ram_we, 0);
    chk("rst_level", a_level, 0);
    chk("rst_b_level", b_level, 0);

    // latency: push at edge k, pop_valid after edge k+2
    a_cycle(1'b1, 32'hA5, 1'b0, pu, po);
    chk("lat_k_valid", a_pop_valid, 0);
    chk("lat_k_level", a_level, 1);
    a_cycle(1'b0, 32'h0, 1'b0, pu, po);
    chk("lat_k1_valid", a_pop_valid, 0);
    chk("lat_k1_level", a_level, 1);
    a_cycle(1'b0, 32'h0, 1'b0, pu, po);
    chk("lat_k2_valid", a_pop_valid, 1);
    chk("lat_k2_data", a_pop_data, 32'hA5);
    chk("lat_k2_level", a_level, 1);
    a_cycle(1'b0, 32'h0, 1'b1, pu, po);
    chk("lat_popped", po, 1);
    chk("lat_after_valid", a_pop_valid, 0);
    chk("lat_after_level", a_level, 0);

    // fill: 0..9 offered with no pops, capacity 4 + 2
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      a_cycle(1'b1, i, 1'b0, pu, po);
      accepted += int'(pu);
    end
    chk("fill_accepted", accepted, 6);
    chk("fill_push_ready", a_push_ready, 0);
    chk("fill_level", a_level, 6);
    chk("fill_head", a_pop_data, 0);
    a_drain("fill_drain");
    chk("fill_empty_valid", a_pop_valid, 0);
    chk("fill_empty_level", a_level, 0);

    // streaming: 100 words, both sides always ready
    pops = 0; first_pop = -1; level_bad = 0; accepted = 0;
    for (int c = 0; c < 103; c++) begin
      a_cycle(accepted < 100, accepted, 1'b1, pu, po);
      accepted += int'(pu);
      if (po) begin
        pops++;
        if (first_pop < 0) first_pop = c;
      end
      if (a_level > 3) level_bad++;
    end
    chk("stream_pops", pops, 100);
    chk("stream_first_pop", first_pop, 3);
    chk("stream_level_over3", level_bad, 0);
    chk("stream_left", sbq_a.size(), 0);

    // wrap-around: 20 rounds of 3 words
    for (int r = 0; r < 20; r++) begin
      accepted = 0;
      for (int j = 0; j < 3; j++) begin
        a_cycle(1'b1, 32'h100 + r * 3 + j, 1'b0, pu, po);
        accepted += int'(pu);
      end
      chk("wrap_accepted", accepted, 3);
      a_drain("wrap_drain");
    end

    // reset mid-operation: ram_count 3, inflight 1, oq_count 1
    for (int i = 0; i < 5; i++) a_cycle(1'b1, 32'h50 + i, 1'b0, pu, po);
    a_cycle(1'b1, 32'h55, 1'b1, pu, po);
    chk("mid_level", a_level, 5);
    a_push_valid = 1'b0; a_pop_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_push_ready", a_push_ready, 1);
    chk("mid_rst_pop_valid", a_pop_valid, 0);
    chk("mid_rst_pop_data", a_pop_data, 0);
    chk("mid_rst_ram_we", a_ram_we, 0);
    chk("mid_rst_level", a_level, 0);
    sbq_a.delete();
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_level", a_level, 0);
    a_cycle(1'b1, 32'h11, 1'b0, pu, po);
    a_cycle(1'b0, 32'h0, 1'b0, pu, po);
    a_cycle(1'b0, 32'h0, 1'b0, pu, po);
    chk("post_rst_head", a_pop_data, 32'h11);
    a_drain("post_rst_drain");
    chk("post_rst_empty", a_pop_valid, 0);
    chk("post_rst_level0", a_level, 0);

    // backpressure on instance B: random push_valid / pop_ready over 1000 words
    b_pushed_n = 0; b_popped_n = 0; cyc = 0; b_prev_stall = 0; b_prev_data = 0;
    while (b_popped_n < 1000 && cyc < 20000) begin
      b_push_valid = (b_pushed_n < 1000) && ($urandom_range(0, 1) == 1);
      b_push_data  = 32'h8000_0000 + b_pushed_n;
      b_pop_ready  = ($urandom_range(0, 1) == 1);
      #1;
      if (b_prev_stall) begin
        chk("bp_stall_valid", b_pop_valid, 1);
        chk("bp_stall_data", b_pop_data, b_prev_data);
      end
      if (b_push_valid && b_push_ready) begin
        sbq_b.push_back(b_push_data);
        b_pushed_n++;
      end
      if (b_pop_valid && b_pop_ready) begin
        b_exp = (sbq_b.size() > 0) ? sbq_b[0] : 32'hDEAD_BEEF;
        chk("bp_pop_data", b_pop_data, b_exp);
        if (sbq_b.size() > 0) void'(sbq_b.pop_front());
        b_popped_n++;
      end
      if (b_level > 5'd10) chk("bp_level_max", b_level, 10);
      b_prev_stall = b_pop_valid && !b_pop_ready;
      b_prev_data  = b_pop_data;
      @(posedge clk); #1;
      cyc++;
    end
    b_push_valid = 1'b0; b_pop_ready = 1'b0;
    chk("bp_popped", b_popped_n, 1000);
    chk("bp_left", sbq_b.size(), 0);
    chk("bp_empty_valid", b_pop_valid, 0);
    chk("bp_empty_level", b_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
